hex_scan_driver: RTL and testbench
==================================

Name: hex_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment driver for the board hex displays (hex_seg/hex_grid style outputs).
- Supersedes the fixed 4-digit combinational hex drivers.
- Adds:
  - configurable digit count
  - programmable scan prescaler
  - inter-digit ghost blanking
  - frame-synchronous data snapshot with hold
  - leading-zero suppression
  - per-digit decimal points
- One instance per display bank; the top level instantiates two (A and B).

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
DIV, 50000, Clk cycles per digit slot (>= 2)
BLANK_CYCLES, 500, cycles at start of each slot with all grids off (0 <= BLANK_CYCLES < DIV)
SEG_ACTIVE_LOW, 1, 1: segment drive inverted at output
GRID_ACTIVE_LOW, 1, 1: grid drive inverted at output

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous reset, active-low (0 = reset)
data_in  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k (digit 0 = least significant, rightmost)
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_lz  in  1  1 = suppress leading zeros
hold  in  1  1 = freeze displayed snapshot
hex_seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
hex_grid  out  NUM_DIGITS  one-hot digit enable, polarity per GRID_ACTIVE_LOW
frame_start  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset asserted (async): clear all of the following immediately, without waiting for a Clk edge:
  - prescaler cnt=0, digit index idx=0
  - snapshot=0, dp snapshot=0
  - frame_start=0
  - all segments and grids off (active-low defaults: hex_seg=8'hFF, hex_grid=all 1s)
- Reset deasserts: the first Clk edge begins counting from cnt=0, idx=0.
- Prescaler:
  - cnt counts 0..DIV-1, then wraps to 0.
  - tick = (cnt==DIV-1).
- Digit index: on tick, idx increments; NUM_DIGITS-1 wraps to 0.
- Snapshot:
  - On the tick edge where idx wraps to 0, snapshot <= data_in and dp snapshot <= dp_in, unless hold=1, in which case both retain their value.
  - Data is never torn mid-frame.
- frame_start: registered; high for exactly the one cycle in which idx==0 && cnt==0 following a wrap. It is not asserted on the first post-reset cycle.
- Leading-zero blanking:
  - Digit k (k>=1) is blanked iff blank_lz=1 and snapshot nibbles k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit shows all segments off, including dp.
- Output stage (all outputs registered; one-cycle latency from the (cnt, idx) state):
  - cnt < BLANK_CYCLES: grid all off, segments all off (ghost blanking).
  - Otherwise: grid bit idx on, all other grid bits off; segments = decode(snapshot nibble idx) with dp = dp snapshot[idx].
- Decode, active-high gfedcba:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Polarity: SEG_ACTIVE_LOW inverts all 8 segment bits; GRID_ACTIVE_LOW inverts all grid bits.
- Simultaneous events:
  - blank_lz and hold are sampled combinationally at use; blank_lz changes take effect on the next output register update.
  - hold changing on the wrap edge: the value present at that edge decides whether the snapshot loads.
- Data changes between wraps are invisible until the next wrap.

Test Plan (NUM_DIGITS=4, DIV=4, BLANK_CYCLES=1, both polarities active-low):
1. Reset low, then high -> hex_seg=FF, hex_grid=F, no frame_start during reset. After release, the first frame shows snapshot 0 on digit 0 (seg=C0 when grid=E); digits 1-3 show C0 when blank_lz=0.
2. data_in=16'h12AF, hold=0, run 2 frames -> per 4-cycle slot: 1 cycle grid=F, then 3 cycles grid=E/D/B/7 with seg=8E(F)/88(A)/A4(2)/F9(1); frame_start every 16 cycles.
3. data_in=16'h0005, blank_lz=1 -> digit0 seg=92; digits 1-3 segments FF while their grid slot is active. With data_in=16'h0105: digit2 seg=F9, digit1 seg=C0 (embedded zero shown), digit3 seg=FF.
4. Snapshot 16'h1234, then hold=1 and data_in=16'hFFFF for 3 frames -> display unchanged. Drop hold -> the next frame shows FFFF (seg=8E all digits).
5. Change data_in mid-frame (at idx=1) -> current frame still shows the old value; the new value appears only after frame_start.
6. Assert Reset at idx=2, cnt=2 -> outputs go FF/F within the same cycle (asynchronous). After release, scanning restarts at idx=0 and the snapshot reads 0.

Source files
------------

// File: rtl/hex_scan_driver.sv
// Time-multiplexed seven-segment driver with a prescaled digit scan, ghost blanking,
// a frame-synchronous data snapshot with hold, and leading-zero suppression.
module hex_scan_driver #(
  parameter int NUM_DIGITS      = 4,
  parameter int DIV             = 50000,
  parameter int BLANK_CYCLES    = 500,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit GRID_ACTIVE_LOW = 1'b1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  input  logic                      hold,
  output logic [7:0]                hex_seg,
  output logic [NUM_DIGITS-1:0]     hex_grid,
  output logic                      frame_start
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] GRID_OFF = GRID_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   snap_q, snap_d;
  logic [NUM_DIGITS-1:0]     dpSnap_q, dpSnap_d;
  logic [7:0]                seg_q, seg_d;
  logic [NUM_DIGITS-1:0]     grid_q, grid_d;
  logic                      frameStart_q, frameStart_d;

  logic                      tick;
  logic                      wrap;
  logic [3:0]                curNibble;
  logic                      curDp;
  logic                      upperZero;
  logic                      ghost;
  logic                      lzBlank;
  logic [NUM_DIGITS-1:0]     gridOnehot;
  logic [7:0]                segActive;
  logic [NUM_DIGITS-1:0]     gridActive;

  // The snapshot only moves on the wrap edge, so a frame never mixes old and new data.
  always_comb begin
    tick         = (cnt_q == CW'(DIV - 1));
    wrap         = tick && (idx_q == IW'(NUM_DIGITS - 1));
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    snap_d       = (wrap && !hold) ? data_in : snap_q;
    dpSnap_d     = (wrap && !hold) ? dp_in : dpSnap_q;
    frameStart_d = wrap;
  end

  always_comb begin
    curNibble  = 4'h0;
    curDp      = 1'b0;
    upperZero  = 1'b1;
    gridOnehot = '0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (idx_q == IW'(j)) begin
        curNibble     = snap_q[4*j +: 4];
        curDp         = dpSnap_q[j];
        gridOnehot[j] = 1'b1;
      end
      if ((IW'(j) >= idx_q) && (snap_q[4*j +: 4] != 4'h0)) begin
        upperZero = 1'b0;
      end
    end
    ghost   = (int'(cnt_q) < BLANK_CYCLES);
    lzBlank = blank_lz && (idx_q != '0) && upperZero;
    if (ghost) begin
      segActive  = 8'h00;
      gridActive = '0;
    end else begin
      segActive  = lzBlank ? 8'h00 : {curDp, decode(curNibble)};
      gridActive = gridOnehot;
    end
    seg_d  = SEG_ACTIVE_LOW ? ~segActive : segActive;
    grid_d = GRID_ACTIVE_LOW ? ~gridActive : gridActive;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      dpSnap_q     <= '0;
      seg_q        <= SEG_OFF;
      grid_q       <= GRID_OFF;
      frameStart_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      dpSnap_q     <= dpSnap_d;
      seg_q        <= seg_d;
      grid_q       <= grid_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign hex_seg     = seg_q;
  assign hex_grid    = grid_q;
  assign frame_start = frameStart_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Scoreboard bench for hex_scan_driver: a cycle-count reference model queues the expected
// display word for every clock, and a negedge monitor pops and compares it.
module tb_hex_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = N * DIV;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  hex_seg;
  logic [3:0]  hex_grid;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int scanNo = 0;

  logic [12:0] expQ[$];
  logic [6:0]  segTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int          s;
  logic [15:0] snap;
  logic [3:0]  dpSnap;

  hex_scan_driver #(
    .NUM_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(BLANK),
    .SEG_ACTIVE_LOW(1'b1), .GRID_ACTIVE_LOW(1'b1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .data_in(data_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .hold(hold),
    .hex_seg(hex_seg), .hex_grid(hex_grid), .frame_start(frame_start)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Expected {frame_start, grid, seg} for the display slot reached after `st` clock edges.
  function automatic logic [12:0] expectedOut(input int st, input logic [15:0] sn,
                                              input logic [3:0] dps, input logic lz, input logic fs);
    int         digit;
    int         offset;
    logic [3:0] nib;
    logic [7:0] segOn;
    logic [3:0] gridOn;
    digit  = (st / DIV) % N;
    offset = st % DIV;
    nib    = 4'(sn >> (4 * digit));
    if (offset < BLANK) begin
      segOn  = 8'h00;
      gridOn = 4'h0;
    end else begin
      gridOn = 4'(1 << digit);
      if (lz && digit > 0 && (sn >> (4 * digit)) == 16'h0000) segOn = 8'h00;
      else segOn = {dps[digit], segTable[nib]};
    end
    return {fs, ~gridOn, ~segOn};
  endfunction

  initial begin
    logic wrapNow;
    s = 0; snap = 16'h0000; dpSnap = 4'h0;
    forever begin
      @(posedge Clk or negedge Reset);
      if (!Reset) begin
        s = 0; snap = 16'h0000; dpSnap = 4'h0;
        expQ.delete();
      end else begin
        wrapNow = ((s % FRAME) == FRAME - 1);
        expQ.push_back(expectedOut(s, snap, dpSnap, blank_lz, wrapNow));
        if (wrapNow && !hold) begin
          snap   = data_in;
          dpSnap = dp_in;
        end
        s++;
      end
    end
  end

  initial begin
    logic [12:0] e;
    forever begin
      @(negedge Clk);
      if (Reset && expQ.size() > 0) begin
        e = expQ.pop_front();
        scanNo++;
        checkOutput($sformatf("scan#%0d", scanNo), {3'b000, frame_start, hex_grid, hex_seg}, {3'b000, e});
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp, input logic lz,
                               input logic h, input int cycles);
    data_in  = d;
    dp_in    = dp;
    blank_lz = lz;
    hold     = h;
    repeat (cycles) @(negedge Clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_seg"}, {8'h00, hex_seg}, 16'h00FF);
    checkOutput({tag, "_grid"}, {12'h000, hex_grid}, 16'h000F);
    checkOutput({tag, "_fs"}, {15'h0000, frame_start}, 16'h0000);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic found;
    #2 Reset = 1'b0;
    #1 checkResetState("reset_async");
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checkOutput("fs_in_reset", {15'h0000, frame_start}, 16'h0000);
    end
    Reset = 1'b1;

    applyStimulus(16'h0000, 4'h0, 1'b0, 1'b0, FRAME + 2);
    applyStimulus(16'h12AF, 4'h0, 1'b0, 1'b0, 3 * FRAME);
    applyStimulus(16'h0005, 4'h0, 1'b1, 1'b0, 2 * FRAME);
    applyStimulus(16'h0105, 4'h0, 1'b1, 1'b0, 2 * FRAME);
    applyStimulus(16'h1234, 4'h5, 1'b0, 1'b0, 2 * FRAME);
    applyStimulus(16'hFFFF, 4'hF, 1'b0, 1'b1, 3 * FRAME);
    applyStimulus(16'hFFFF, 4'h0, 1'b0, 1'b0, 2 * FRAME);
    applyStimulus(16'h8421, 4'h2, 1'b0, 1'b0, 2 * FRAME + 5);
    applyStimulus(16'h0C00, 4'h8, 1'b1, 1'b0, 2 * FRAME);

    data_in = 16'h0700; dp_in = 4'h0; blank_lz = 1'b0; hold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge Clk);
      if ((s % FRAME) == 10) found = 1'b1;
    end
    checkOutput("align_idx2_cnt2", {15'h0000, found}, 16'h0001);
    #2 Reset = 1'b0;
    #1 checkResetState("reset_midframe");
    @(negedge Clk);
    checkResetState("reset_held");
    @(negedge Clk);
    Reset = 1'b1;
    applyStimulus(16'h0700, 4'h0, 1'b0, 1'b0, 2 * FRAME);

    for (int k = 0; k < 150; k++) begin
      applyStimulus(16'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(1, 20)));
    end

    repeat (2) @(negedge Clk);
    checkOutput("queue_drained", 16'(expQ.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
